// File: rtl/clk_div_pkg.sv
// Shared constants and sizing helper for the clk_div_gen clock-enable generator.
// The optional phase-restart input is enabled with CLKDIV_SYNC_EN.
package clk_div_pkg;
  localparam int CH_MAX          = 8;
  localparam int DIV_W_DEF       = 16;
  localparam int LOCK_CYCLES_DEF = 1024;

  // Width needed to count 0..v-1. Never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow divisor, down-counter, registered tick and square wave.
// With CLKDIV_SYNC_EN a sync input reloads the phase and clears clk_sq.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 68
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             tick,
  output logic             clk_sq
);
  localparam logic [DIV_W-1:0] RST_DIV    = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] RST_RELOAD = (DIV_RST == 0) ? '0 : DIV_W'(DIV_RST - 1);

  logic [DIV_W-1:0] shadow, cnt, nxt_shadow, reload;
  logic             restart;

`ifdef CLKDIV_SYNC_EN
  assign restart = sync;
`else
  assign restart = 1'b0;
`endif

  // A load in the same cycle as a reload is taken by that reload; 0 acts as 1.
  always_comb begin
    nxt_shadow = load ? val : shadow;
    reload     = (nxt_shadow == '0) ? '0 : nxt_shadow - 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RST_DIV;
      cnt    <= RST_RELOAD;
      tick   <= 1'b0;
      clk_sq <= 1'b0;
    end else begin
      shadow <= nxt_shadow;
      if (!run || restart) begin
        cnt    <= reload;
        tick   <= 1'b0;
        clk_sq <= 1'b0;
      end else if (cnt == '0) begin
        cnt    <= reload;
        tick   <= 1'b1;
        clk_sq <= ~clk_sq;
      end else begin
        cnt    <= cnt - 1'b1;
        tick   <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel fabric clock-enable generator with a PLL-style lock holdoff.
// Define CLKDIV_SYNC_EN to add the sync_restart phase-alignment input.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CH          = 2,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_RST     = 68,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic [CH*DIV_W-1:0] div_val,
  input  logic [CH-1:0]       div_load,
  input  logic [CH-1:0]       en,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync_restart,
`endif
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       clk_sq,
  output logic                lock
);
  localparam int LW = clog2(LOCK_CYCLES);

  if (CH < 1 || CH > CH_MAX) begin : g_bad_ch
    $error("clk_div_gen: CH out of range");
  end

  logic [LW-1:0]             hold_cnt;
  logic [CH-1:0][DIV_W-1:0]  div_vec;

  assign div_vec = div_val;

  // Holdoff counter stops at LOCK_CYCLES-1; lock follows one edge later.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      lock     <= 1'b0;
    end else if (!lock) begin
      if (hold_cnt == LW'(LOCK_CYCLES - 1)) lock <= 1'b1;
      else                                  hold_cnt <= hold_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    clk_div_chan #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
    ) u_chan (
      .clkin (clkin),
      .rst_n (rst_n),
      .run   (lock & en[i]),
      .load  (div_load[i]),
      .val   (div_vec[i]),
`ifdef CLKDIV_SYNC_EN
      .sync  (sync_restart),
`endif
      .tick  (tick[i]),
      .clk_sq(clk_sq[i])
    );
  end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised fabric clock-enable generator: successor to the fixed single-ratio PLL wrapper.
- Produces CH independent channels from clkin. Each channel has:
  - a runtime-programmable divisor;
  - a one-cycle tick enable;
  - a divided square wave.
- Provides a lock/ready indication after a holdoff, mirroring PLL LOCK.
- Feeds the I2C bit-rate and OLED refresh timing without extra PLL outputs.

Parameters:
- CH, 2, number of output channels (1..8).
- DIV_W, 16, divisor width per channel.
- DIV_RST, 68, reset divisor loaded into every channel.
- LOCK_CYCLES, 1024, clkin cycles after reset release before lock asserts (>=1).

Ports:
- clkin  input  1  single system clock.
- rst_n  input  1  asynchronous active-low reset.
- div_val  input  CH*DIV_W  requested divisor per channel; channel i occupies bits [i*DIV_W +: DIV_W].
- div_load  input  CH  per-channel one-cycle load strobe for div_val.
- en  input  CH  per-channel run enable.
- tick  output  CH  one-clkin-cycle pulse per divisor period.
- clk_sq  output  CH  registered square wave, toggles on each tick.
- lock  output  1  high once the holdoff expires; stays high until reset.

Behaviour:
- Reset is asynchronous and active-low, with one clock. While rst_n=0:
  - lock=0, tick=0, clk_sq=0;
  - active divisor = shadow divisor = DIV_RST;
  - every counter = DIV_RST-1;
  - holdoff counter = 0.
- Effective divisor D = max(div, 1): a value of 0 is treated as 1.
- Lock:
  - The holdoff counter increments each cycle after reset release.
  - lock rises registered on the cycle the count reaches LOCK_CYCLES-1, then the counter saturates.
  - While lock=0, all counters hold their reload value and tick=0, clk_sq=0.
- Channel run, when lock=1 and en[i]=1:
  - The counter decrements each cycle.
  - At 0, tick[i]=1 for exactly one cycle (registered), clk_sq[i] toggles, and the counter reloads D-1.
  - Tick period is D cycles. clk_sq period is 2D cycles with 50% duty.
  - First tick occurs D cycles after en rises, or D cycles after lock rises if en is already high.
- D=1: tick stays high continuously and clk_sq toggles every cycle.
- Channel disable (en[i]=0):
  - counter reloads D-1, tick=0, clk_sq forced to 0 on the next edge;
  - re-enabling restarts the phase from scratch.
- Divisor load:
  - div_load[i] captures that channel's div_val slice into its shadow register.
  - Running channel: the shadow is applied at the next terminal count, so there is no runt period.
  - Disabled channel, or lock=0: applied immediately, and the counter reloads new D-1.
  - Load coincident with terminal count: the new value is used for that same reload.
  - Back-to-back loads before a terminal count: the last one wins.
- Channels are independent; a load or enable on one channel never perturbs another.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous); lock must re-expire.
- Output latency: tick and clk_sq are flop outputs with no combinational path from any input.

Optional Feature:
- Macro CLKDIV_SYNC_EN.
- Defined: adds input sync_restart (1 bit).
  - When high for one cycle, every enabled channel's counter reloads D-1 (applying any pending shadow) and clk_sq is cleared.
  - This phase-aligns all channels; tick is suppressed that cycle.
  - If sync_restart coincides with a terminal count, the restart wins: no tick.
- Undefined: the port is absent and channels free-run independently.

Decomposition:
- Package clk_div_pkg holds:
  - constant CH_MAX=8;
  - the default DIV_W and LOCK_CYCLES;
  - function clog2 for sizing the holdoff counter.
- Sub-module clk_div_chan is one channel: counter, shadow register, tick and clk_sq flops.
  - Its inputs are clkin, rst_n, run (=lock&en[i]), load, val, and sync under the macro.
  - The top generates CH instances and the shared lock counter.

Test Plan:
- Reset release with LOCK_CYCLES=16, en=2'b11, defaults -> lock rises at cycle 16. First tick on each channel occurs 68 cycles later, then every 68. clk_sq period is 136.
- Ch0 running D=68; load div_val=10 mid-period -> the current 68-cycle period completes intact, then ticks every 10 cycles. Ch1 is unaffected.
- Load div_val=0 and div_val=1 -> both give tick continuously high and clk_sq toggling every cycle.
- en[0] dropped mid-count, then raised again after 5 cycles -> tick=0 and clk_sq=0 while low; first tick comes exactly D cycles after the rise.
- Load coincident with terminal count (D=4 → 7) -> the next period is 7 cycles. Two loads (5 then 9) in one period -> 9 applied.
- rst_n pulsed low mid-run -> outputs clear asynchronously. With CLKDIV_SYNC_EN, sync_restart on channels at D=3 and D=5 -> both first ticks land 3 and 5 cycles after the restart.
